// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN popcount/threshold stage: FSM state
// encoding, default widths, and a width-parameterised saturating adder.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int PSUM_WIDTH_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 12;
  localparam int SAT_MAX_W      = 32;

  // Returns {saturated, value}; value is clamped to 2^w - 1.
  function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                 input logic [SAT_MAX_W-1:0] b,
                                                 input int unsigned w);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    if (sum > lim) return {1'b1, lim[SAT_MAX_W-1:0]};
    return {1'b0, sum[SAT_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/bnn_thresh_regfile.sv
// Per-channel threshold store: synchronous write, asynchronous read by channel.
// Optional per-channel sign-flip bit when BNN_THRESH_SIGN_FLIP_EN is defined.
module bnn_thresh_regfile #(
  parameter int NUM_CH    = 16,
  parameter int ACC_WIDTH = 12,
  parameter int CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_addr,
  input  logic [ACC_WIDTH-1:0] wr_data,
`ifdef BNN_THRESH_SIGN_FLIP_EN
  input  logic                 wr_flip,
  output logic                 rd_flip,
`endif
  input  logic [CH_W-1:0]      rd_addr,
  output logic [ACC_WIDTH-1:0] rd_thr
);

  logic [ACC_WIDTH-1:0] thr [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) thr[i] <= '0;
    end else if (wr_en) begin
      thr[wr_addr] <= wr_data;
    end
  end

  assign rd_thr = thr[rd_addr];

`ifdef BNN_THRESH_SIGN_FLIP_EN
  logic flip [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) flip[i] <= 1'b0;
    end else if (wr_en) begin
      flip[wr_addr] <= wr_flip;
    end
  end

  assign rd_flip = flip[rd_addr];
`endif

endmodule

// File: rtl/bnn_popcount_threshold.sv
// Accumulates PE-column partial popcounts per channel, thresholds the total and
// emits one activation bit per channel. Optional macro: BNN_THRESH_SIGN_FLIP_EN.
//
// state   | meaning
// IDLE    | waiting for the first partial sum of a channel
// ACCUM   | accepting remaining partial sums
// COMPARE | one cycle: register acc >= thr[ch] and the channel index
// OUTPUT  | out_valid high until the consumer takes the bit
module bnn_popcount_threshold
  import bnn_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int NUM_PASSES = 9,
  parameter int NUM_CH     = 16,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  psum_valid,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic                  psum_ready,
  input  logic                  thr_wr_en,
  input  logic [CH_W-1:0]       thr_wr_addr,
  input  logic [ACC_WIDTH-1:0]  thr_wr_data,
`ifdef BNN_THRESH_SIGN_FLIP_EN
  input  logic                  thr_wr_flip,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [CH_W-1:0]       out_ch,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PC_W = $clog2(NUM_PASSES + 1);

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [PC_W-1:0]      pass_cnt;
  logic [CH_W-1:0]      ch;
  logic [ACC_WIDTH-1:0] thr_rd;
  logic                 flip_rd;
  logic                 accept;
  logic                 last_pass;
  logic                 cmp_bit;
  logic [SAT_MAX_W:0]   add_res;
  logic                 unused_add;

  bnn_thresh_regfile #(
    .NUM_CH   (NUM_CH),
    .ACC_WIDTH(ACC_WIDTH),
    .CH_W     (CH_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (thr_wr_en),
    .wr_addr(thr_wr_addr),
    .wr_data(thr_wr_data),
`ifdef BNN_THRESH_SIGN_FLIP_EN
    .wr_flip(thr_wr_flip),
    .rd_flip(flip_rd),
`endif
    .rd_addr(ch),
    .rd_thr (thr_rd)
  );

`ifndef BNN_THRESH_SIGN_FLIP_EN
  assign flip_rd = 1'b0;
`endif

  assign accept     = psum_valid && psum_ready;
  assign last_pass  = (state == IDLE) ? (NUM_PASSES == 1)
                                      : (pass_cnt == PC_W'(NUM_PASSES - 1));
  assign add_res    = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(psum_in), ACC_WIDTH);
  assign unused_add = ^add_res[SAT_MAX_W-1:ACC_WIDTH];
  // Read port still shows the pre-write value during a same-cycle write.
  assign cmp_bit    = (acc >= thr_rd) ^ flip_rd;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_pass ? COMPARE : ACCUM;
      ACCUM:   if (accept && last_pass) state_next = COMPARE;
      COMPARE: if (en) state_next = OUTPUT;
      OUTPUT:  if (en && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    psum_ready = en && !rst && (state == IDLE || state == ACCUM);
    out_valid  = (state == OUTPUT);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      pass_cnt <= '0;
      ch       <= '0;
      out_bit  <= 1'b0;
      out_ch   <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (accept) begin
          acc      <= ACC_WIDTH'(psum_in);
          pass_cnt <= PC_W'(1);
        end
        ACCUM: if (accept) begin
          acc      <= add_res[ACC_WIDTH-1:0];
          pass_cnt <= pass_cnt + PC_W'(1);
          if (add_res[SAT_MAX_W]) overflow <= 1'b1;
        end
        COMPARE: begin
          out_bit <= cmp_bit;
          out_ch  <= ch;
        end
        OUTPUT: if (out_ready) begin
          acc      <= '0;
          pass_cnt <= '0;
          ch       <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
